// File: rtl/iq_sample_decimator.sv
// iq_sample_decimator: gated multi-lane I/Q capture with phase tags and boxcar decimation.
// Define SAMPLER_RETRIGGER_EN to let start restart a window that is already running.
module iq_sample_decimator #(
  parameter int LANES     = 5,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 11,
  parameter int DEC_W     = 6,
  parameter int PHASE_MOD = 50,
  parameter int PHASE_W   = 6,
  parameter int ACC_W     = 32
) (
  input  logic                       clk100,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LANES*DATA_W-1:0]    data_i_in,
  input  logic [LANES*DATA_W-1:0]    data_q_in,
  input  logic [3:0]                 demod_freq,
  input  logic [LEN_W-1:0]           sample_length,
  input  logic [DEC_W-1:0]           sample_freq,
  output logic [LANES*DATA_W-1:0]    data_i_shift,
  output logic [LANES*DATA_W-1:0]    data_q_shift,
  output logic [LANES*PHASE_W-1:0]   phase_vals,
  output logic [ACC_W-1:0]           sum_i,
  output logic [ACC_W-1:0]           sum_q,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [PHASE_W:0] L_PM = (PHASE_W+1)'(PHASE_MOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [3:0]               r_df;
  logic [LEN_W-1:0]         r_remain;
  logic [DEC_W-1:0]         r_freq;
  logic [DEC_W-1:0]         r_cnt;
  logic [PHASE_W-1:0]       r_base;
  logic [ACC_W-1:0]         r_acc_i;
  logic [ACC_W-1:0]         r_acc_q;
  logic [ACC_W-1:0]         r_sum_i;
  logic [ACC_W-1:0]         r_sum_q;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_busy;
  logic                     r_done;
  logic [LANES*DATA_W-1:0]  r_di;
  logic [LANES*DATA_W-1:0]  r_dq;
  logic [LANES*PHASE_W-1:0] r_phase;

  logic [PHASE_W:0]         w_df_mod;
  logic [PHASE_W:0]         w_off [LANES];
  logic [PHASE_W:0]         w_step;
  logic [PHASE_W-1:0]       w_base_nxt;
  logic [LANES*PHASE_W-1:0] w_ph;
  logic [ACC_W-1:0]         w_lsum_i;
  logic [ACC_W-1:0]         w_lsum_q;
  logic [ACC_W-1:0]         w_tot_i;
  logic [ACC_W-1:0]         w_tot_q;
  logic [DEC_W-1:0]         w_fac;
  logic [DEC_W:0]           w_cnt_inc;
  logic                     w_win_full;
  logic                     w_last;
  logic                     w_retrig;

`ifdef SAMPLER_RETRIGGER_EN
  assign w_retrig = start;
`else
  assign w_retrig = 1'b0;
`endif

  // Reduce the latched frequency into one phase turn.
  always_comb begin
    w_df_mod = {{(PHASE_W-3){1'b0}}, r_df};
    if (w_df_mod >= L_PM) w_df_mod = w_df_mod - L_PM;
  end

  // Per-lane phase offsets l*df mod PHASE_MOD and per-clock base step.
  always_comb begin : p_lane_off
    logic [PHASE_W:0] v_o;
    v_o = '0;
    for (int l = 0; l < LANES; l++) begin
      w_off[l] = v_o;
      v_o = v_o + w_df_mod;
      if (v_o >= L_PM) v_o = v_o - L_PM;
    end
    w_step = v_o;
  end

  // Lane phases for this clock and next base, wrapped by subtraction.
  always_comb begin : p_phase
    logic [PHASE_W:0] v_p;
    v_p = '0;
    w_ph = '0;
    for (int l = 0; l < LANES; l++) begin
      v_p = {1'b0, r_base} + w_off[l];
      if (v_p >= L_PM) v_p = v_p - L_PM;
      w_ph[l*PHASE_W +: PHASE_W] = v_p[PHASE_W-1:0];
    end
    v_p = {1'b0, r_base} + w_step;
    if (v_p >= L_PM) v_p = v_p - L_PM;
    w_base_nxt = v_p[PHASE_W-1:0];
  end

  // Sign-extended sum of all lanes of the current clock.
  always_comb begin : p_lane_sum
    logic [DATA_W-1:0] v_i;
    logic [DATA_W-1:0] v_q;
    v_i = '0;
    v_q = '0;
    w_lsum_i = '0;
    w_lsum_q = '0;
    for (int l = 0; l < LANES; l++) begin
      v_i = data_i_in[l*DATA_W +: DATA_W];
      v_q = data_q_in[l*DATA_W +: DATA_W];
      w_lsum_i = w_lsum_i
               + {{(ACC_W-DATA_W){v_i[DATA_W-1]}}, v_i};
      w_lsum_q = w_lsum_q
               + {{(ACC_W-DATA_W){v_q[DATA_W-1]}}, v_q};
    end
  end

  assign w_tot_i    = r_acc_i + w_lsum_i;
  assign w_tot_q    = r_acc_q + w_lsum_q;
  assign w_fac      = (r_freq == '0) ? DEC_W'(1) : r_freq;
  assign w_cnt_inc  = {1'b0, r_cnt} + (DEC_W+1)'(1);
  assign w_win_full = (w_cnt_inc == {1'b0, w_fac});
  assign w_last     = (r_remain == LEN_W'(1));

  // Capture FSM: config latch, phase base, accumulation and strobes.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_df        <= '0;
      r_remain    <= '0;
      r_freq      <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_sum_i     <= '0;
      r_sum_q     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_df     <= demod_freq;
            r_remain <= sample_length;
            r_freq   <= sample_freq;
            r_base   <= '0;
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ARM;
          end
        end
        S_ARM: begin
          if (r_remain == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_retrig) begin
            r_df     <= demod_freq;
            r_remain <= sample_length;
            r_freq   <= sample_freq;
            r_base   <= '0;
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_cnt    <= '0;
            r_state  <= S_ARM;
          end else begin
            r_remain <= r_remain - LEN_W'(1);
            r_base   <= w_last ? '0 : w_base_nxt;
            if (w_win_full || w_last) begin
              r_sum_i     <= w_tot_i;
              r_sum_q     <= w_tot_q;
              r_out_valid <= 1'b1;
              r_out_last  <= w_last;
              r_acc_i     <= '0;
              r_acc_q     <= '0;
              r_cnt       <= '0;
            end else begin
              r_acc_i <= w_tot_i;
              r_acc_q <= w_tot_q;
              r_cnt   <= w_cnt_inc[DEC_W-1:0];
            end
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data pass-through and phase tags, registered together for alignment.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_di    <= '0;
      r_dq    <= '0;
      r_phase <= '0;
    end else begin
      r_di <= data_i_in;
      r_dq <= data_q_in;
      if (r_state == S_RUN && !w_retrig) r_phase <= w_ph;
      else r_phase <= '0;
    end
  end

  assign data_i_shift = r_di;
  assign data_q_shift = r_dq;
  assign phase_vals   = r_phase;
  assign sum_i        = r_sum_i;
  assign sum_q        = r_sum_q;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_iq_sample_decimator.sv
// tb_iq_sample_decimator: random and directed windows against a
// sample-level reference model of capture, phase and decimation.
module tb_iq_sample_decimator;

  localparam int LANES     = 5;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 11;
  localparam int DEC_W     = 6;
  localparam int PHASE_MOD = 50;
  localparam int PHASE_W   = 6;
  localparam int ACC_W     = 32;
  localparam int DW        = LANES*DATA_W;
  localparam int PWT       = LANES*PHASE_W;
  localparam int MAXC      = 160;

  logic             clk100 = 1'b0;
  logic             reset;
  logic             start;
  logic [DW-1:0]    data_i_in;
  logic [DW-1:0]    data_q_in;
  logic [3:0]       demod_freq;
  logic [LEN_W-1:0] sample_length;
  logic [DEC_W-1:0] sample_freq;
  logic [DW-1:0]    data_i_shift;
  logic [DW-1:0]    data_q_shift;
  logic [PWT-1:0]   phase_vals;
  logic [ACC_W-1:0] sum_i;
  logic [ACC_W-1:0] sum_q;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             done;

  always #5 clk100 = ~clk100;

  iq_sample_decimator dut (
    .clk100        (clk100),
    .reset         (reset),
    .start         (start),
    .data_i_in     (data_i_in),
    .data_q_in     (data_q_in),
    .demod_freq    (demod_freq),
    .sample_length (sample_length),
    .sample_freq   (sample_freq),
    .data_i_shift  (data_i_shift),
    .data_q_shift  (data_q_shift),
    .phase_vals    (phase_vals),
    .sum_i         (sum_i),
    .sum_q         (sum_q),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  // stimulus per edge index c
  logic [DW-1:0]    di [MAXC];
  logic [DW-1:0]    dq [MAXC];
  logic             st [MAXC];
  logic [3:0]       cdf [MAXC];
  logic [LEN_W-1:0] clen [MAXC];
  logic [DEC_W-1:0] cfr [MAXC];
  // expected values after edge c
  logic             ev [MAXC];
  logic             el [MAXC];
  logic             ed [MAXC];
  logic             eb [MAXC];
  logic [ACC_W-1:0] esi [MAXC];
  logic [ACC_W-1:0] esq [MAXC];
  logic [PWT-1:0]   eph [MAXC];
  // captured values after edge c
  logic             cv [MAXC];
  logic             cl [MAXC];
  logic             cd [MAXC];
  logic             cb [MAXC];
  logic [ACC_W-1:0] csi [MAXC];
  logic [ACC_W-1:0] csq [MAXC];
  logic [PWT-1:0]   cph [MAXC];
  logic [DW-1:0]    cdi [MAXC];
  logic [DW-1:0]    cdq [MAXC];

  int errors = 0;
  int checks = 0;

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      for (int l = 0; l < LANES; l++) begin
        di[c][l*DATA_W +: DATA_W] = DATA_W'($urandom);
        dq[c][l*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      st[c]   = 1'b0;
      cdf[c]  = 4'($urandom);
      clen[c] = LEN_W'($urandom);
      cfr[c]  = DEC_W'($urandom);
      ev[c] = 1'b0; el[c] = 1'b0;
      ed[c] = 1'b0; eb[c] = 1'b0;
      esi[c] = '0; esq[c] = '0;
      eph[c] = '0;
    end
  endtask

  task automatic set_const(input logic [DATA_W-1:0] iv,
                           input logic [DATA_W-1:0] qv);
    for (int c = 0; c < MAXC; c++)
      for (int l = 0; l < LANES; l++) begin
        di[c][l*DATA_W +: DATA_W] = iv;
        dq[c][l*DATA_W +: DATA_W] = qv;
      end
  endtask

  // Reference: window started at edge s; clock k is consumed at
  // edge s+1+k. ab>0 is the edge where a restart abandons it.
  task automatic model_win(input int s, input int len, input int fr,
                           input int df, input int ab);
    int f, ai, aq, cnt, kmax, hi, c, n;
    st[s]   = 1'b1;
    clen[s] = LEN_W'(len);
    cfr[s]  = DEC_W'(fr);
    cdf[s]  = 4'(df);
    f    = (fr == 0) ? 1 : fr;
    kmax = (ab > 0) ? ab - s - 2 : len;
    hi   = (ab > 0) ? ab - 1 : s + len;
    for (int b = s; b <= hi; b++) eb[b] = 1'b1;
    ai = 0; aq = 0; cnt = 0;
    for (int k = 1; k <= kmax; k++) begin
      c = s + 1 + k;
      for (int l = 0; l < LANES; l++) begin
        ai += $signed(di[c][l*DATA_W +: DATA_W]);
        aq += $signed(dq[c][l*DATA_W +: DATA_W]);
        n = (k - 1) * LANES + l;
        eph[c][l*PHASE_W +: PHASE_W] = PHASE_W'((n * df) % PHASE_MOD);
      end
      cnt++;
      if (cnt == f || k == len) begin
        ev[c] = 1'b1;
        el[c] = (k == len);
        esi[c] = ai;
        esq[c] = aq;
        ai = 0; aq = 0; cnt = 0;
      end
    end
    if (ab == 0) ed[s+len+2] = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      start = st[c];
      data_i_in = di[c];
      data_q_in = dq[c];
      demod_freq = cdf[c];
      sample_length = clen[c];
      sample_freq = cfr[c];
      @(posedge clk100);
      #1;
      cv[c] = out_valid; cl[c] = out_last;
      cd[c] = done; cb[c] = busy;
      csi[c] = sum_i; csq[c] = sum_q;
      cph[c] = phase_vals;
      cdi[c] = data_i_shift; cdq[c] = data_q_shift;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_stim();
    reset = 1'b1;
    run_cycles(3);
    checks++;
    if ({cdi[2], cdq[2]} !== '0) begin
      errors++;
      $display("FAIL rst_data got=%0h req=0", {cdi[2], cdq[2]});
    end
    checks++;
    if ({csi[2], csq[2], cph[2]} !== '0) begin
      errors++;
      $display("FAIL rst_sum_ph got=%0h req=0", {csi[2], csq[2], cph[2]});
    end
    checks++;
    if ({cv[2], cl[2], cb[2], cd[2]} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got=%b req=0000", {cv[2], cl[2], cb[2], cd[2]});
    end
    reset = 1'b0;
    clear_stim();
    model_win(0, 20, 5, 3, 0);
    run_cycles(7);
    checks++;
    if (cb[6] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_busy got=%b req=1", cb[6]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_last, done} !== 4'b0) begin
      errors++;
      $display("FAIL async_rst_flags got=%b req=0000", {busy, out_valid, out_last, done});
    end
    checks++;
    if ({sum_i, sum_q, phase_vals, data_i_shift} !== '0) begin
      errors++;
      $display("FAIL async_rst_vals got=%0h req=0", {sum_i, sum_q, phase_vals});
    end
    @(posedge clk100);
    #1;
    reset = 1'b0;
    clear_stim();
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks++;
      if ({cv[c], cl[c], cd[c], cb[c]} !== 4'b0) begin
        errors++;
        $display("FAIL post_rst c=%0d got=%b req=0000", c, {cv[c], cl[c], cd[c], cb[c]});
      end
    end
  endtask

  task automatic test_const();
    clear_stim();
    set_const(16'd1, 16'hFFFF);
    model_win(0, 20, 5, 0, 0);
    run_cycles(25);
    for (int c = 0; c < 25; c++) begin
      checks++;
      if ({cv[c], cl[c], cd[c], cb[c]} !== {ev[c], el[c], ed[c], eb[c]}) begin
        errors++;
        $display("FAIL const_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c], cb[c]}, {ev[c], el[c], ed[c], eb[c]});
      end
      if (ev[c]) begin
        checks++;
        if (csi[c] !== 32'd25 || csq[c] !== 32'hFFFF_FFE7) begin
          errors++;
          $display("FAIL const_sum c=%0d got=%0h/%0h req=19/ffffffe7", c, csi[c], csq[c]);
        end
      end
    end
    checks++;
    if ({cl[21], cd[22]} !== 2'b11) begin
      errors++;
      $display("FAIL const_last_done got=%b req=11", {cl[21], cd[22]});
    end
  endtask

  task automatic test_phase_df5();
    logic [PWT-1:0] p0, p1;
    p0 = {6'd20, 6'd15, 6'd10, 6'd5, 6'd0};
    p1 = {6'd45, 6'd40, 6'd35, 6'd30, 6'd25};
    clear_stim();
    model_win(0, 6, 1, 5, 0);
    run_cycles(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cph[c] !== eph[c]) begin
        errors++;
        $display("FAIL df5_phase c=%0d got=%0h req=%0h", c, cph[c], eph[c]);
      end
    end
    checks++;
    if (cph[2] !== p0 || cph[3] !== p1 || cph[4] !== p0) begin
      errors++;
      $display("FAIL df5_seq got=%0h,%0h,%0h req=%0h,%0h", cph[2], cph[3], cph[4], p0, p1);
    end
  endtask

  task automatic test_phase_df11();
    clear_stim();
    model_win(0, 100, $urandom_range(0, 20), 11, 0);
    run_cycles(104);
    for (int c = 0; c < 104; c++) begin
      checks++;
      if (cph[c] !== eph[c]) begin
        errors++;
        $display("FAIL df11_phase c=%0d got=%0h req=%0h", c, cph[c], eph[c]);
      end
      checks++;
      if (cdi[c] !== di[c] || cdq[c] !== dq[c]) begin
        errors++;
        $display("FAIL df11_shift c=%0d got=%0h req=%0h", c, cdi[c], di[c]);
      end
      checks++;
      if ({cv[c], cl[c], cd[c]} !== {ev[c], el[c], ed[c]}) begin
        errors++;
        $display("FAIL df11_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c]}, {ev[c], el[c], ed[c]});
      end
      if (ev[c]) begin
        checks++;
        if (csi[c] !== esi[c] || csq[c] !== esq[c]) begin
          errors++;
          $display("FAIL df11_sum c=%0d got=%0h/%0h req=%0h/%0h", c, csi[c], csq[c], esi[c], esq[c]);
        end
      end
    end
    checks++;
    if (cph[2][4*PHASE_W +: PHASE_W] !== 6'd44) begin
      errors++;
      $display("FAIL df11_lane4 got=%0d req=44", cph[2][4*PHASE_W +: PHASE_W]);
    end
  endtask

  task automatic test_partial();
    clear_stim();
    set_const(16'd2, 16'd3);
    model_win(0, 7, 5, 1, 0);
    run_cycles(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({cv[c], cl[c], cd[c]} !== {ev[c], el[c], ed[c]}) begin
        errors++;
        $display("FAIL part_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c]}, {ev[c], el[c], ed[c]});
      end
    end
    checks++;
    if (csi[6] !== 32'd50 || csi[8] !== 32'd20 || cl[8] !== 1'b1) begin
      errors++;
      $display("FAIL part_sums got=%0d,%0d last=%b req=50,20 last=1", csi[6], csi[8], cl[8]);
    end
  endtask

  task automatic test_len0_freq0();
    int nv;
    clear_stim();
    model_win(0, 0, 5, 2, 0);
    model_win(3, 3, 0, 2, 0);
    run_cycles(10);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (cv[c]) nv++;
      checks++;
      if ({cv[c], cl[c], cd[c], cb[c]} !== {ev[c], el[c], ed[c], eb[c]}) begin
        errors++;
        $display("FAIL l0f0_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c], cb[c]}, {ev[c], el[c], ed[c], eb[c]});
      end
      if (ev[c]) begin
        checks++;
        if (csi[c] !== esi[c] || csq[c] !== esq[c]) begin
          errors++;
          $display("FAIL l0f0_sum c=%0d got=%0h req=%0h", c, csi[c], esi[c]);
        end
      end
    end
    checks++;
    if (cd[2] !== 1'b1 || nv !== 3) begin
      errors++;
      $display("FAIL l0f0_count done2=%b strobes=%0d req=1,3", cd[2], nv);
    end
  endtask

  task automatic test_retrigger();
    clear_stim();
`ifdef SAMPLER_RETRIGGER_EN
    model_win(0, 20, 5, 3, 9);
    model_win(9, 20, 5, 7, 0);
`else
    model_win(0, 20, 5, 3, 0);
    st[9] = 1'b1;
`endif
    run_cycles(36);
    for (int c = 0; c < 36; c++) begin
      checks++;
      if ({cv[c], cl[c], cd[c], cb[c]} !== {ev[c], el[c], ed[c], eb[c]}) begin
        errors++;
        $display("FAIL retrig_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c], cb[c]}, {ev[c], el[c], ed[c], eb[c]});
      end
      checks++;
      if (cph[c] !== eph[c]) begin
        errors++;
        $display("FAIL retrig_phase c=%0d got=%0h req=%0h", c, cph[c], eph[c]);
      end
      if (ev[c]) begin
        checks++;
        if (csi[c] !== esi[c] || csq[c] !== esq[c]) begin
          errors++;
          $display("FAIL retrig_sum c=%0d got=%0h req=%0h", c, csi[c], esi[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int s, len;
    clear_stim();
    s = 0;
    for (int w = 0; w < 4; w++) begin
      len = $urandom_range(0, 25);
      model_win(s, len, $urandom_range(0, 7), $urandom_range(0, 15), 0);
      st[s+len+2] = 1'b1;
      s += len + 3;
    end
    run_cycles(s + 2);
    for (int c = 0; c < s + 2; c++) begin
      checks++;
      if ({cv[c], cl[c], cd[c], cb[c]} !== {ev[c], el[c], ed[c], eb[c]}) begin
        errors++;
        $display("FAIL b2b_flags c=%0d got=%b req=%b", c, {cv[c], cl[c], cd[c], cb[c]}, {ev[c], el[c], ed[c], eb[c]});
      end
      checks++;
      if (cph[c] !== eph[c]) begin
        errors++;
        $display("FAIL b2b_phase c=%0d got=%0h req=%0h", c, cph[c], eph[c]);
      end
      if (ev[c]) begin
        checks++;
        if (csi[c] !== esi[c] || csq[c] !== esq[c]) begin
          errors++;
          $display("FAIL b2b_sum c=%0d got=%0h/%0h req=%0h/%0h", c, csi[c], csq[c], esi[c], esq[c]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    data_i_in = '0;
    data_q_in = '0;
    demod_freq = '0;
    sample_length = '0;
    sample_freq = '0;
    test_reset();
    test_const();
    test_phase_df5();
    test_phase_df11();
    test_partial();
    test_len0_freq0();
    test_retrigger();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
